// File: rtl/algo_yuv444_2rgb888_if.sv
// rtl/algo_yuv444_2rgb888_if.sv - YCbCr 4:4:4 in / RGB888 out pixel bus with sync signals
interface algo_yuv444_2rgb888_if;
  logic [7:0] i_y_8b;
  logic [7:0] i_cb_8b;
  logic [7:0] i_cr_8b;
  logic       i_vs;
  logic       i_hs;
  logic       i_data_en;
  logic [7:0] o_r_8b;
  logic [7:0] o_g_8b;
  logic [7:0] o_b_8b;
  logic       o_vs;
  logic       o_hs;
  logic       o_data_en;

  modport master (
    output i_y_8b, i_cb_8b, i_cr_8b, i_vs, i_hs, i_data_en,
    input  o_r_8b, o_g_8b, o_b_8b, o_vs, o_hs, o_data_en
  );

  modport slave (
    input  i_y_8b, i_cb_8b, i_cr_8b, i_vs, i_hs, i_data_en,
    output o_r_8b, o_g_8b, o_b_8b, o_vs, o_hs, o_data_en
  );
endinterface

// File: rtl/algo_yuv444_2rgb888.sv
// rtl/algo_yuv444_2rgb888.sv - 4-stage BT.601 YCbCr444 to RGB888 converter with matched sync delay
// Define ALGO_YUV2RGB_FULL_RANGE_EN for full-range (JPEG) coefficients; default is studio range.
module algo_yuv444_2rgb888 #(
  parameter bit OUT_BLANK = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  algo_yuv444_2rgb888_if.slave  pix
);

`ifdef ALGO_YUV2RGB_FULL_RANGE_EN
  localparam logic signed [9:0]  Y_OFS = 10'sd0;
  localparam logic signed [19:0] K_Y   = 20'sd256;
  localparam logic signed [19:0] K_RCR = 20'sd359;
  localparam logic signed [19:0] K_GCB = 20'sd88;
  localparam logic signed [19:0] K_GCR = 20'sd183;
  localparam logic signed [19:0] K_BCB = 20'sd454;
`else
  localparam logic signed [9:0]  Y_OFS = 10'sd16;
  localparam logic signed [19:0] K_Y   = 20'sd298;
  localparam logic signed [19:0] K_RCR = 20'sd409;
  localparam logic signed [19:0] K_GCB = 20'sd100;
  localparam logic signed [19:0] K_GCR = 20'sd208;
  localparam logic signed [19:0] K_BCB = 20'sd516;
`endif

  localparam logic signed [19:0] ROUND = 20'sd128;

  logic signed [9:0]  yo;
  logic signed [8:0]  cbo;
  logic signed [8:0]  cro;
  logic signed [19:0] p_y;
  logic signed [19:0] p_rcr;
  logic signed [19:0] p_gcb;
  logic signed [19:0] p_gcr;
  logic signed [19:0] p_bcb;
  logic signed [19:0] s_r;
  logic signed [19:0] s_g;
  logic signed [19:0] s_b;
  logic [3:0]         vs_sr;
  logic [3:0]         hs_sr;
  logic [3:0]         den_sr;
  logic [7:0]         r_q;
  logic [7:0]         g_q;
  logic [7:0]         b_q;
  logic [7:0]         r_c;
  logic [7:0]         g_c;
  logic [7:0]         b_c;
  logic               blank;
  logic               unused_lsbs;

  // Operates on sum[19:8], i.e. the floor of sum/256; bit 11 is the sign.
  function automatic logic [7:0] clamp8(input logic [11:0] q);
    if (q[11])
      return 8'd0;
    else if (|q[10:8])
      return 8'hFF;
    else
      return q[7:0];
  endfunction

  always_comb begin
    r_c   = clamp8(s_r[19:8]);
    g_c   = clamp8(s_g[19:8]);
    b_c   = clamp8(s_b[19:8]);
    blank = OUT_BLANK && !den_sr[2];
  end

  assign unused_lsbs = ^{s_r[7:0], s_g[7:0], s_b[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yo     <= '0;
      cbo    <= '0;
      cro    <= '0;
      p_y    <= '0;
      p_rcr  <= '0;
      p_gcb  <= '0;
      p_gcr  <= '0;
      p_bcb  <= '0;
      s_r    <= '0;
      s_g    <= '0;
      s_b    <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      vs_sr  <= '0;
      hs_sr  <= '0;
      den_sr <= '0;
    end else begin
      yo     <= $signed({2'b00, pix.i_y_8b}) - Y_OFS;
      cbo    <= $signed({1'b0, pix.i_cb_8b}) - 9'sd128;
      cro    <= $signed({1'b0, pix.i_cr_8b}) - 9'sd128;

      p_y    <= $signed({{10{yo[9]}}, yo}) * K_Y;
      p_rcr  <= $signed({{11{cro[8]}}, cro}) * K_RCR;
      p_gcb  <= $signed({{11{cbo[8]}}, cbo}) * K_GCB;
      p_gcr  <= $signed({{11{cro[8]}}, cro}) * K_GCR;
      p_bcb  <= $signed({{11{cbo[8]}}, cbo}) * K_BCB;

      s_r    <= p_y + p_rcr + ROUND;
      s_g    <= p_y - p_gcb - p_gcr + ROUND;
      s_b    <= p_y + p_bcb + ROUND;

      // den_sr[2] becomes o_data_en on this same edge, so it gates the RGB register.
      r_q    <= blank ? 8'd0 : r_c;
      g_q    <= blank ? 8'd0 : g_c;
      b_q    <= blank ? 8'd0 : b_c;

      vs_sr  <= {vs_sr[2:0], pix.i_vs};
      hs_sr  <= {hs_sr[2:0], pix.i_hs};
      den_sr <= {den_sr[2:0], pix.i_data_en};
    end
  end

  assign pix.o_r_8b    = r_q;
  assign pix.o_g_8b    = g_q;
  assign pix.o_b_8b    = b_q;
  assign pix.o_vs      = vs_sr[3];
  assign pix.o_hs      = hs_sr[3];
  assign pix.o_data_en = den_sr[3];

endmodule
